// File: rtl/lc3_regfile_pkg.sv
// LC-3 write-back types: word, register index and condition-code bundle.
// Shared by the register file, its interface and the N/Z/P generator.
package lc3_regfile_pkg;

    localparam int DATA_W    = 16;
    localparam int NUM_REGS  = 8;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [DATA_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } nzp_t;

    localparam nzp_t NZP_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

endpackage

// File: rtl/lc3_regfile_wb_if.sv
// Datapath-side bundle of the LC-3 register file: bus, selects, strobes.
// The control/datapath side is the master; the register file is the slave.
interface lc3_regfile_wb_if;
    import lc3_regfile_pkg::*;

    word_t    bus_in;
    reg_idx_t dr_sel;
    logic     ld_reg;
    reg_idx_t sr1_sel;
    reg_idx_t sr2_sel;
    logic     ld_cc;
    logic     ld_ben;
    logic [2:0] ir_nzp;
    word_t    sr1_out;
    word_t    sr2_out;
    logic     n_out;
    logic     z_out;
    logic     p_out;
    logic     ben_out;

    modport master (
        output bus_in, dr_sel, ld_reg, sr1_sel, sr2_sel,
        output ld_cc, ld_ben, ir_nzp,
        input  sr1_out, sr2_out, n_out, z_out, p_out, ben_out
    );

    modport slave (
        input  bus_in, dr_sel, ld_reg, sr1_sel, sr2_sel,
        input  ld_cc, ld_ben, ir_nzp,
        output sr1_out, sr2_out, n_out, z_out, p_out, ben_out
    );

endinterface

// File: rtl/lc3_nzp_gen.sv
// Condition-code classifier: exactly one of N/Z/P for any bus word.
module lc3_nzp_gen
    import lc3_regfile_pkg::*;
(
    input  word_t word,
    output nzp_t  nzp
);

    // Sign bit gives N, all-zero gives Z, everything else is P
    always_comb begin
        nzp   = NZP_RESET;
        nzp.n = word[DATA_W-1];
        nzp.z = (word == '0);
        nzp.p = ~nzp.n & ~nzp.z;
    end

endmodule

// File: rtl/lc3_regfile_wb.sv
// LC-3 write-back: R0-R7, N/Z/P condition codes and BEN flag.
// Define REGFILE_BYPASS_EN to forward bus_in to a read port being written.
module lc3_regfile_wb
    import lc3_regfile_pkg::*;
(
    input logic              Clk,
    input logic              Reset,
    lc3_regfile_wb_if.slave  rf
);

    word_t               regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_en;
    nzp_t                cc;
    nzp_t                cc_nxt;
    logic                ben;
    logic                ben_nxt;

    lc3_nzp_gen u_nzp (
        .word (rf.bus_in),
        .nzp  (cc_nxt)
    );

    // One-hot write enable from the destination index
    always_comb begin
        wr_en = '0;
        if (rf.ld_reg) begin
            wr_en[rf.dr_sel] = 1'b1;
        end
    end

    // Register array: only the enabled register takes the bus
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_en[i]) begin
                    regs[i] <= rf.bus_in;
                end
            end
        end
    end

    // Branch enable evaluated against the flags held before this edge
    always_comb begin
        ben_nxt = |(rf.ir_nzp & {cc.n, cc.z, cc.p});
    end

    // Condition codes and BEN latch on their own strobes
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cc  <= NZP_RESET;
            ben <= 1'b0;
        end else begin
            if (rf.ld_cc) begin
                cc <= cc_nxt;
            end
            if (rf.ld_ben) begin
                ben <= ben_nxt;
            end
        end
    end

    // Read ports, optionally forwarding the word being written
    always_comb begin
        rf.sr1_out = regs[rf.sr1_sel];
        rf.sr2_out = regs[rf.sr2_sel];
`ifdef REGFILE_BYPASS_EN
        if (rf.ld_reg && (rf.sr1_sel == rf.dr_sel)) begin
            rf.sr1_out = rf.bus_in;
        end
        if (rf.ld_reg && (rf.sr2_sel == rf.dr_sel)) begin
            rf.sr2_out = rf.bus_in;
        end
`else
`endif
    end

    assign rf.n_out   = cc.n;
    assign rf.z_out   = cc.z;
    assign rf.p_out   = cc.p;
    assign rf.ben_out = ben;

endmodule

// File: doc/lc3_regfile_wb.md
Name: lc3_regfile_wb

Overview:
- Write-back end of the LC-3 datapath: takes the 16-bit bus and demultiplexes it into one of eight general registers (R0–R7) selected by DR.
- Also latches the N/Z/P condition codes and the BEN branch-enable flag.
- Provides two combinational read ports (SR1, SR2) feeding the ALU and address-adder source selection.
- Sits between the bus gate selection and the ALU operand inputs; driven by the control FSM load strobes.

Parameters:
- DATA_W, 16, width of each register and of the bus.
- NUM_REGS, 8, number of general registers; DR/SR index width is clog2(NUM_REGS) = 3.

Ports:
- Clk  in  1  system clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset
- bus_in  in  DATA_W  datapath bus value to be written
- dr_sel  in  3  destination register index
- ld_reg  in  1  write strobe; bus_in goes to R[dr_sel] at the next edge
- sr1_sel  in  3  read port 1 index
- sr2_sel  in  3  read port 2 index
- ld_cc  in  1  condition-code load strobe
- ld_ben  in  1  BEN load strobe
- ir_nzp  in  3  IR[11:9] branch mask, with n = [2], z = [1], p = [0]
- sr1_out  out  DATA_W  contents of R[sr1_sel]
- sr2_out  out  DATA_W  contents of R[sr2_sel]
- n_out  out  1  registered N flag
- z_out  out  1  registered Z flag
- p_out  out  1  registered P flag
- ben_out  out  1  registered branch-enable

Behaviour:
- Reset (Reset = 0, asynchronous, takes effect with no clock edge, including mid-operation):
  - R0–R7 = 16'h0000.
  - n_out = 0, z_out = 1, p_out = 0.
  - ben_out = 0.
  - While Reset is held, all strobes are ignored.
  - First update occurs on the first rising edge after Reset deasserts.
- Write path:
  - dr_sel is decoded to a one-hot enable of 8 bits.
  - On a rising edge with ld_reg = 1, only R[dr_sel] takes bus_in; all other registers hold.
  - ld_reg = 0 means no register changes.
  - Write latency is 1 cycle: the new value is visible on the read ports in the cycle after the edge.
- Read path:
  - Purely combinational from the register array: sr1_out = R[sr1_sel], sr2_out = R[sr2_sel].
  - No read latency.
  - sr1_sel == sr2_sel is legal; both outputs carry the same value.
- Read-during-write (same index written and read in one cycle):
  - The read returns the old value until the edge (base build; see Optional Feature).
- Condition codes, on a rising edge with ld_cc = 1:
  - N = bus_in[15].
  - Z = (bus_in == 0).
  - P = ~N & ~Z.
- CC invariants:
  - Exactly one of n/z/p is high at all times, including after reset.
  - ld_cc = 0 means the flags hold.
- Simultaneous ld_reg and ld_cc: both sample the same bus_in on the same edge.
- BEN, on a rising edge with ld_ben = 1:
  - ben_out = (ir_nzp[2] & n_out) | (ir_nzp[1] & z_out) | (ir_nzp[0] & p_out).
  - It uses the currently registered flags, i.e. pre-update values if ld_cc is also asserted that edge.
  - ld_ben = 0 means BEN holds.
- No register is hardwired: R0 is writable.
- All three strobes may be asserted together.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - When ld_reg = 1 and sr1_sel == dr_sel, sr1_out = bus_in combinationally in that same cycle.
  - The same rule applies independently to sr2_sel.
  - The register update timing itself is unchanged.
- Undefined: read ports always show the stored value (old value during the write cycle).

Decomposition:
- Package lc3_regfile_pkg:
  - DATA_W, NUM_REGS, REG_IDX_W = 3.
  - typedef word_t (logic [15:0]).
  - typedef reg_idx_t (logic [2:0]).
  - typedef struct nzp_t {n, z, p}.
  - constant NZP_RESET = {0, 1, 0}.
- One sub-module: lc3_nzp_gen.
  - Combinational, word_t in, nzp_t out.
  - Instantiated for the CC next-state so the bench can check it standalone.
- Write decoder and read muxes stay inline.

Test Plan:
- Reset low mid-run after R3 = 16'hBEEF and p = 1 → immediately, with no clock edge, all sr outputs read 0000, nzp = 010, ben = 0.
- ld_reg = 1, dr_sel = 5, bus_in = 16'h1234 for one edge → R5 = 1234 and R0–R4, R6, R7 unchanged (write a distinct pattern to each beforehand and read all 8 back via sr1/sr2).
- ld_cc with bus_in = 16'h8000 → nzp = 100; with 16'h0000 → 010; with 16'h7FFF → 001; with ld_cc = 0 and bus_in = 16'h8000 → flags hold.
- nzp = 001, then ld_ben = 1 with ir_nzp = 3'b001 → ben = 1; with ir_nzp = 3'b110 → ben = 0; ld_ben and ld_cc on the same edge with bus_in = 0 and ir_nzp = 3'b010 → ben = 0, since the pre-update P was set.
- R2 = 16'h00AA, then ld_reg = 1, dr_sel = 2, bus_in = 16'h0055, sr1_sel = sr2_sel = 2 → during the write cycle sr outputs show 00AA (base) or 0055 (REGFILE_BYPASS_EN); the next cycle shows 0055 in both builds.
- ld_reg, ld_cc and ld_ben all asserted with dr_sel = 7 and bus_in = 16'hFFFF → R7 = FFFF and nzp = 100 after the edge; ben is computed from the prior flags.
